dmem_lsu_ctrl: RTL and testbench
================================

# dmem_lsu_ctrl

Load/store controller that sequences every core data access onto the word-wide data memory port. It accepts one RISC-V load or store per request, performs byte/halfword extraction with sign/zero extension, and implements sub-word stores as a read-modify-write. It sits between the execute stage (requester) and the data memory, and is the only master allowed to drive the memory's write and read enables.

## Interface
- `WORD_SIZE`, default 32: data width. Fixed at 32 for RV32.
- `ADDR_WIDTH`, default 32: byte-address width.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_Req`  in  1  request valid. Sampled only in IDLE.
- `i_We`  in  1  1 = store, 0 = load.
- `i_Funct3`  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU. Any other code is treated as W.
- `i_Addr`  in  ADDR_WIDTH  byte address.
- `i_Wd`  in  WORD_SIZE  store data; only the low 8 or 16 bits are used for B or H.
- `o_Ack`  out  1  one-cycle completion pulse.
- `o_Rd`  out  WORD_SIZE  extended load result; valid while `o_Ack`=1.
- `o_Busy`  out  1  high in every state except IDLE.
- `o_Misalign`  out  1  misaligned-access flag; pulses with `o_Ack`. Tied to 0 when the macro is not defined.
- `o_Mem_Addr`  out  ADDR_WIDTH  word address, equal to the latched byte address >> 2.
- `o_Mem_Wd`  out  WORD_SIZE  merged write word.
- `o_Mem_Wen`  out  1  memory write enable.
- `o_Mem_Ren`  out  1  memory read enable.
- `i_Mem_Rd`  in  WORD_SIZE  memory read data; combinational and valid in the same cycle as `o_Mem_Ren`.

## Operation
- FSM states:
  - IDLE: waits for a request.
  - READ: `o_Mem_Ren`=1; `i_Mem_Rd` is captured into the data register.
  - WRITE: `o_Mem_Wen`=1; `o_Mem_Wd` is driven from the merge register.
  - DONE: `o_Ack`=1.
- Transitions:
  - IDLE & `i_Req`: latch `i_Addr`, `i_Funct3`, `i_We`, `i_Wd`.
    - Word store goes to WRITE.
    - Any other access goes to READ.
  - READ:
    - Load goes to DONE.
    - Sub-word store goes to WRITE.
  - WRITE goes to DONE.
  - DONE goes to IDLE unconditionally.
- Load extraction uses byte lane `Addr[1:0]`:
  - B sign-extends bit 7 of the lane; BU zero-extends.
  - H and HU select the halfword at `Addr[1]`, then sign- or zero-extend it.
  - W passes the word through.
- Store merge: SB/SH replace only the addressed lane(s) of the word captured in READ; all other bytes are preserved.
- Handshake:
  - The requester holds its signals stable from acceptance and deasserts `i_Req` on the edge where it samples `o_Ack`=1.
  - If `i_Req` is still high in the following IDLE cycle, a new transaction is accepted.
- `o_Mem_Addr`, `o_Mem_Wen`, `o_Mem_Ren` and `o_Mem_Wd` are decoded from the state and latched registers only (Moore). They never depend combinationally on the `i_` request inputs.
- Register and output update rules:
  - `o_Rd` is registered and updated at the end of READ.
  - `o_Rd` holds its value outside DONE.
  - After a store or a misaligned access, `o_Rd` is 0.

## Timing
- Reset values: state IDLE, all outputs 0 (including `o_Rd`, `o_Mem_Addr`, `o_Mem_Wd`).
- Reset asserted mid-operation forces IDLE immediately. `o_Mem_Wen` drops asynchronously, so a write in progress is aborted and no ack is issued.
- Latency, counted as cycles from the acceptance edge until `o_Ack` is high:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Misaligned access with the macro defined: 1 cycle.
- Throughput: one transaction per (latency + 1) cycles.
- `i_Req` in READ, WRITE or DONE is ignored.
- At most one of `o_Mem_Wen`/`o_Mem_Ren` is high in any cycle.

## Configuration
- `DMEM_LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned cases: H/HU/SH with `Addr[0]`=1, or W/SW with `Addr[1:0]`≠0.
  - A misaligned access goes IDLE→DONE with no memory access.
  - `o_Misalign`=1 with `o_Ack`, and `o_Rd`=0.
- Macro not defined:
  - Offending low address bits are ignored: H uses `Addr[1]` only, W ignores `Addr[1:0]`.
  - `o_Misalign` is constant 0.

## Structure
- Package `lsu_pkg` holds:
  - the state enum (IDLE, READ, WRITE, DONE);
  - the funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the lane-extract and lane-merge functions.
- One combinational sub-module, `lsu_lane`, performs extraction and merge from (word, funct3, `Addr[1:0]`, store data). The FSM stays in `dmem_lsu_ctrl`.

## Test plan
- Memory word 0x80 = 0x8844_22F1, LB at 0x80: `o_Rd`=0xFFFF_FFF1 with ack 2 cycles after acceptance. LBU at 0x83: `o_Rd`=0x0000_0088.
- LH at 0x82 with the same word: `o_Rd`=0xFFFF_8844. LHU at 0x80: `o_Rd`=0x0000_22F1.
- SB of 0xAB at 0x81 over 0x8844_22F1: READ then WRITE, `o_Mem_Wd`=0x8844_ABF1, ack 3 cycles after acceptance. A subsequent LW returns 0x8844_ABF1.
- SW of 0xDEAD_BEEF at 0x84: no `o_Mem_Ren`, one `o_Mem_Wen` cycle with `o_Mem_Addr`=0x21, ack 2 cycles after acceptance.
- LW at 0x86:
  - With the macro defined: `o_Misalign`=1, `o_Rd`=0, no memory enables, ack 1 cycle after acceptance.
  - Without the macro: the word at 0x84 is returned.
- SH accepted, `i_rst_n` pulled low during WRITE: `o_Mem_Wen` falls immediately, no `o_Ack`, memory word unchanged, `o_Busy`=0. `i_Req` held high through DONE → a back-to-back second transaction starts in the next IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the dmem_lsu_ctrl load/store unit: FSM state encoding, funct3
// access codes and the byte-lane extract/merge helpers.
package lsu_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Reserved funct3 codes fall through to word handling everywhere below.
   function automatic logic is_sub_word(input logic [2:0] funct3);
      return (funct3 == F3_B) || (funct3 == F3_BU) || (funct3 == F3_H) || (funct3 == F3_HU);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic mis;
      case (funct3)
         F3_B, F3_BU: mis = 1'b0;
         F3_H, F3_HU: mis = off[0];
         default:     mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

   function automatic logic [XLEN-1:0] lane_extract(input logic [XLEN-1:0] word,
                                                    input logic [2:0]      funct3,
                                                    input logic [1:0]      off);
      logic [7:0]      b;
      logic [15:0]     h;
      logic [XLEN-1:0] res;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_B:    res = {{24{b[7]}}, b};
         F3_BU:   res = {24'h0, b};
         F3_H:    res = {{16{h[15]}}, h};
         F3_HU:   res = {16'h0, h};
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [XLEN-1:0] lane_merge(input logic [XLEN-1:0] word,
                                                  input logic [2:0]      funct3,
                                                  input logic [1:0]      off,
                                                  input logic [XLEN-1:0] wd);
      logic [XLEN-1:0] res;
      res = word;
      case (funct3)
         F3_B, F3_BU: res[{off, 3'b000} +: 8] = wd[7:0];
         F3_H, F3_HU: begin
            if (off[1]) res[31:16] = wd[15:0];
            else        res[15:0]  = wd[15:0];
         end
         default:     res = wd;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane unit: load extraction with sign/zero extension and the
// sub-word store merge into a previously read word.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0] i_word,
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_off,
   input  logic [XLEN-1:0] i_wd,
   output logic [XLEN-1:0] o_load,
   output logic [XLEN-1:0] o_merge
);

   always_comb begin
      o_load  = lane_extract(i_word, i_funct3, i_off);
      o_merge = lane_merge(i_word, i_funct3, i_off, i_wd);
   end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer for the word-wide data memory port; sub-word stores are done as
// read-modify-write. Define DMEM_LSU_MISALIGN_TRAP_EN to flag and skip misaligned accesses.
module dmem_lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned WORD_SIZE  = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_Req,
   input  logic                  i_We,
   input  logic [2:0]            i_Funct3,
   input  logic [ADDR_WIDTH-1:0] i_Addr,
   input  logic [WORD_SIZE-1:0]  i_Wd,
   output logic                  o_Ack,
   output logic [WORD_SIZE-1:0]  o_Rd,
   output logic                  o_Busy,
   output logic                  o_Misalign,
   output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
   output logic [WORD_SIZE-1:0]  o_Mem_Wd,
   output logic                  o_Mem_Wen,
   output logic                  o_Mem_Ren,
   input  logic [WORD_SIZE-1:0]  i_Mem_Rd
);

   lsu_state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [2:0]            funct3_q;
   logic                  we_q;
   logic [WORD_SIZE-1:0]  merge_q;
   logic [WORD_SIZE-1:0]  rd_q;
   logic                  mis_now;
   logic [WORD_SIZE-1:0]  lane_load;
   logic [WORD_SIZE-1:0]  lane_merged;
   logic                  accept;

   assign accept = (state_q == IDLE) && i_Req;

   lsu_lane u_lane (
      .i_word   (i_Mem_Rd),
      .i_funct3 (funct3_q),
      .i_off    (addr_q[1:0]),
      .i_wd     (merge_q),
      .o_load   (lane_load),
      .o_merge  (lane_merged)
   );

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
   logic mis_q;

   assign mis_now = is_misaligned(i_Funct3, i_Addr[1:0]);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mis_q <= 1'b0;
      end else if (accept) begin
         mis_q <= mis_now;
      end
   end

   assign o_Misalign = (state_q == DONE) && mis_q;
`else
   assign mis_now    = 1'b0;
   assign o_Misalign = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (i_Req) begin
               if (mis_now)                            state_d = DONE;
               else if (i_We && !is_sub_word(i_Funct3)) state_d = WRITE;
               else                                    state_d = READ;
            end
         end
         READ:    state_d = we_q ? WRITE : DONE;
         WRITE:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // merge_q first holds the raw store data, then the merged word once READ completes.
   // rd_q only changes on the edge entering DONE, so it is stable everywhere else.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr_q   <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
         merge_q  <= '0;
         rd_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_Req) begin
                  addr_q   <= i_Addr;
                  funct3_q <= i_Funct3;
                  we_q     <= i_We;
                  merge_q  <= i_Wd;
                  if (mis_now) rd_q <= '0;
               end
            end
            READ: begin
               if (we_q) merge_q <= lane_merged;
               else      rd_q    <= lane_load;
            end
            WRITE:   rd_q <= '0;
            default: ;
         endcase
      end
   end

   always_comb begin
      o_Mem_Ren = 1'b0;
      o_Mem_Wen = 1'b0;
      o_Ack     = 1'b0;
      o_Busy    = (state_q != IDLE);
      unique case (state_q)
         READ:    o_Mem_Ren = 1'b1;
         WRITE:   o_Mem_Wen = 1'b1;
         DONE:    o_Ack     = 1'b1;
         default: ;
      endcase
   end

   assign o_Mem_Addr = {2'b00, addr_q[ADDR_WIDTH-1:2]};
   assign o_Mem_Wd   = merge_q;
   assign o_Rd       = rd_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: directed load/store cases, randomized traffic
// against a behavioural memory model, reset abort and back-to-back handshakes.
module tb_dmem_lsu_ctrl;

   logic        i_clk    = 1'b0;
   logic        i_rst_n  = 1'b0;
   logic        i_Req    = 1'b0;
   logic        i_We     = 1'b0;
   logic [2:0]  i_Funct3 = 3'b000;
   logic [31:0] i_Addr   = 32'h0;
   logic [31:0] i_Wd     = 32'h0;
   logic        o_Ack;
   logic [31:0] o_Rd;
   logic        o_Busy;
   logic        o_Misalign;
   logic [31:0] o_Mem_Addr;
   logic [31:0] o_Mem_Wd;
   logic        o_Mem_Wen;
   logic        o_Mem_Ren;
   logic [31:0] i_Mem_Rd;

   logic [31:0] mem     [0:63];
   logic [31:0] ref_mem [0:63];

   int vectors = 0;
   int errors  = 0;

   dmem_lsu_ctrl dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_Req      (i_Req),
      .i_We       (i_We),
      .i_Funct3   (i_Funct3),
      .i_Addr     (i_Addr),
      .i_Wd       (i_Wd),
      .o_Ack      (o_Ack),
      .o_Rd       (o_Rd),
      .o_Busy     (o_Busy),
      .o_Misalign (o_Misalign),
      .o_Mem_Addr (o_Mem_Addr),
      .o_Mem_Wd   (o_Mem_Wd),
      .o_Mem_Wen  (o_Mem_Wen),
      .o_Mem_Ren  (o_Mem_Ren),
      .i_Mem_Rd   (i_Mem_Rd)
   );

   always #5 i_clk = ~i_clk;

   assign i_Mem_Rd = mem[o_Mem_Addr[5:0]];

   always @(posedge i_clk) begin
      if (o_Mem_Wen) mem[o_Mem_Addr[5:0]] <= o_Mem_Wd;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] f3);
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   function automatic bit model_mis(input logic [2:0] f3, input logic [1:0] off);
      bit en;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
      en = 1'b1;
`else
      en = 1'b0;
`endif
      return en && ((int'(off) % size_of(f3)) != 0);
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] off);
      logic [31:0] v;
      int          sz;
      bit          sgn;
      sz  = size_of(f3);
      sgn = (f3[2] == 1'b0);
      if (sz == 4) return word;
      if (sz == 1) begin
         v = (word >> (8 * int'(off))) & 32'hFF;
         if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      end else begin
         v = (word >> (16 * int'(off[1]))) & 32'hFFFF;
         if (sgn && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] old, input logic [2:0] f3,
                                               input logic [1:0] off, input logic [31:0] wd);
      int          sz;
      int          sh;
      logic [31:0] mask;
      sz = size_of(f3);
      if (sz == 4) return wd;
      sh   = (sz == 1) ? 8 * int'(off) : 16 * int'(off[1]);
      mask = ((sz == 1) ? 32'hFF : 32'hFFFF) << sh;
      return (old & ~mask) | ((wd << sh) & mask);
   endfunction

   // One transaction from acceptance to ack; returns on the cycle o_Ack is sampled high.
   task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input bit keep_req, input string tag);
      int          n;
      int          ren_n;
      int          wen_n;
      int          idx;
      int          sz;
      bit          m;
      bit          both;
      int          exp_lat;
      logic [31:0] exp_rd;
      logic [31:0] exp_word;
      idx      = int'(addr[7:2]);
      sz       = size_of(f3);
      m        = model_mis(f3, addr[1:0]);
      exp_lat  = m ? 1 : ((we && sz != 4) ? 3 : 2);
      exp_rd   = (we || m) ? 32'h0 : model_load(ref_mem[idx], f3, addr[1:0]);
      exp_word = model_store(ref_mem[idx], f3, addr[1:0], wd);
      i_We     = we;
      i_Funct3 = f3;
      i_Addr   = addr;
      i_Wd     = wd;
      i_Req    = 1'b1;
      if (o_Busy) begin
         @(posedge i_clk); #1;
         check({tag, "/idle_gap"}, 32'(o_Busy), 32'd0);
      end
      n = 0; ren_n = 0; wen_n = 0; both = 1'b0;
      do begin
         @(posedge i_clk); #1;
         n++;
         if (o_Mem_Ren) ren_n++;
         if (o_Mem_Ren && o_Mem_Wen) both = 1'b1;
         if (o_Mem_Wen) begin
            wen_n++;
            check({tag, "/wen_addr"}, o_Mem_Addr, {2'b00, addr[31:2]});
            check({tag, "/wen_data"}, o_Mem_Wd, exp_word);
         end
      end while (!o_Ack && n < 10);
      if (!keep_req) i_Req = 1'b0;
      check({tag, "/ack"}, 32'(o_Ack), 32'd1);
      check({tag, "/latency"}, 32'(n), 32'(exp_lat));
      check({tag, "/rd"}, o_Rd, exp_rd);
      check({tag, "/misalign"}, 32'(o_Misalign), 32'(m));
      check({tag, "/ren_cycles"}, 32'(ren_n), (!m && (!we || sz != 4)) ? 32'd1 : 32'd0);
      check({tag, "/wen_cycles"}, 32'(wen_n), (!m && we) ? 32'd1 : 32'd0);
      check({tag, "/exclusive"}, 32'(both), 32'd0);
      if (we && !m) ref_mem[idx] = exp_word;
      check({tag, "/mem"}, mem[idx], ref_mem[idx]);
   endtask

   initial begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr;
      logic [31:0] saved;

      for (int i = 0; i < 64; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[32]     = 32'h8844_22F1;
      ref_mem[32] = 32'h8844_22F1;

      repeat (2) @(posedge i_clk);
      #1;
      check("reset/busy", 32'(o_Busy), 32'd0);
      check("reset/ack", 32'(o_Ack), 32'd0);
      check("reset/rd", o_Rd, 32'd0);
      check("reset/mem_addr", o_Mem_Addr, 32'd0);
      check("reset/mem_wd", o_Mem_Wd, 32'd0);
      check("reset/enables", {30'd0, o_Mem_Wen, o_Mem_Ren}, 32'd0);
      check("reset/misalign", 32'(o_Misalign), 32'd0);
      @(negedge i_clk) i_rst_n = 1'b1;

      txn(1'b0, 3'b000, 32'h80, 32'h0, 1'b0, "lb_80");
      check("lb_80/value", o_Rd, 32'hFFFF_FFF1);
      txn(1'b0, 3'b100, 32'h83, 32'h0, 1'b0, "lbu_83");
      check("lbu_83/value", o_Rd, 32'h0000_0088);
      txn(1'b0, 3'b001, 32'h82, 32'h0, 1'b0, "lh_82");
      check("lh_82/value", o_Rd, 32'hFFFF_8844);
      txn(1'b0, 3'b101, 32'h80, 32'h0, 1'b0, "lhu_80");
      check("lhu_80/value", o_Rd, 32'h0000_22F1);
      txn(1'b1, 3'b000, 32'h81, 32'h0000_00AB, 1'b0, "sb_81");
      check("sb_81/mem_value", mem[32], 32'h8844_ABF1);
      txn(1'b0, 3'b010, 32'h80, 32'h0, 1'b0, "lw_80");
      check("lw_80/value", o_Rd, 32'h8844_ABF1);
      txn(1'b1, 3'b010, 32'h84, 32'hDEAD_BEEF, 1'b0, "sw_84");
      txn(1'b0, 3'b010, 32'h86, 32'h0, 1'b0, "lw_86");

      // Randomized traffic; keep_req sometimes chains transactions back to back.
      for (int t = 0; t < 150; t++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_f3   = r_we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
         r_addr = 32'h80 + 32'($urandom_range(0, 127));
         txn(r_we, r_f3, r_addr, $urandom, 1'($urandom_range(0, 1)), "rand");
      end

      // Reset during the WRITE of a halfword store must abort it without ack.
      saved    = ref_mem[34];
      i_We     = 1'b1;
      i_Funct3 = 3'b001;
      i_Addr   = 32'h88;
      i_Wd     = 32'h5555_1234;
      i_Req    = 1'b1;
      if (o_Busy) begin
         @(posedge i_clk); #1;
      end
      @(posedge i_clk); #1;
      check("rst_abort/read", 32'(o_Mem_Ren), 32'd1);
      @(posedge i_clk); #1;
      check("rst_abort/write", 32'(o_Mem_Wen), 32'd1);
      #1 i_rst_n = 1'b0;
      #1;
      check("rst_abort/wen_drop", 32'(o_Mem_Wen), 32'd0);
      check("rst_abort/busy", 32'(o_Busy), 32'd0);
      check("rst_abort/ack", 32'(o_Ack), 32'd0);
      i_Req = 1'b0;
      @(posedge i_clk); #1;
      check("rst_abort/no_ack", 32'(o_Ack), 32'd0);
      check("rst_abort/mem", mem[34], saved);
      check("rst_abort/rd", o_Rd, 32'd0);
      @(negedge i_clk) i_rst_n = 1'b1;

      // Request held through DONE: the next access must start in the following IDLE cycle.
      txn(1'b0, 3'b010, 32'h80, 32'h0, 1'b1, "b2b_first");
      txn(1'b0, 3'b000, 32'h81, 32'h0, 1'b1, "b2b_second");
      txn(1'b1, 3'b001, 32'h8A, 32'h0000_CAFE, 1'b0, "b2b_third");

      @(posedge i_clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
